// File: rtl/seg_pkg.sv
// Shared definitions for the 7-segment scan decoder: segment patterns,
// pattern decode and the capture FSM state type.
package seg_pkg;

   localparam logic [6:0] SEG_0     = 7'h40;
   localparam logic [6:0] SEG_1     = 7'h79;
   localparam logic [6:0] SEG_2     = 7'h24;
   localparam logic [6:0] SEG_3     = 7'h30;
   localparam logic [6:0] SEG_4     = 7'h19;
   localparam logic [6:0] SEG_5     = 7'h12;
   localparam logic [6:0] SEG_6     = 7'h02;
   localparam logic [6:0] SEG_7     = 7'h78;
   localparam logic [6:0] SEG_8     = 7'h00;
   localparam logic [6:0] SEG_9     = 7'h10;
   localparam logic [6:0] SEG_A     = 7'h08;
   localparam logic [6:0] SEG_B     = 7'h03;
   localparam logic [6:0] SEG_C     = 7'h46;
   localparam logic [6:0] SEG_D     = 7'h21;
   localparam logic [6:0] SEG_E     = 7'h06;
   localparam logic [6:0] SEG_F     = 7'h0E;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   typedef enum logic [1:0] {
      ST_WAIT_STABLE,
      ST_CAPTURE,
      ST_HOLD
   } scan_state_t;

   // Result packing: {err, blank, nibble}
   function automatic logic [5:0] seg_decode(input logic [6:0] pat);
      logic [5:0] r;
      r = 6'b10_0000;
      case (pat)
         SEG_0:     r = {2'b00, 4'h0};
         SEG_1:     r = {2'b00, 4'h1};
         SEG_2:     r = {2'b00, 4'h2};
         SEG_3:     r = {2'b00, 4'h3};
         SEG_4:     r = {2'b00, 4'h4};
         SEG_5:     r = {2'b00, 4'h5};
         SEG_6:     r = {2'b00, 4'h6};
         SEG_7:     r = {2'b00, 4'h7};
         SEG_8:     r = {2'b00, 4'h8};
         SEG_9:     r = {2'b00, 4'h9};
         SEG_A:     r = {2'b00, 4'hA};
         SEG_B:     r = {2'b00, 4'hB};
         SEG_C:     r = {2'b00, 4'hC};
         SEG_D:     r = {2'b00, 4'hD};
         SEG_E:     r = {2'b00, 4'hE};
         SEG_F:     r = {2'b00, 4'hF};
         SEG_BLANK: r = {2'b01, 4'h0};
         default:   r = {2'b10, 4'h0};
      endcase
      return r;
   endfunction

endpackage

// File: rtl/seg_sync_filter.sv
// Two-flop synchronizer on the scanned an/seg pins followed by a stability
// counter that flags when the pin state has dwelt long enough to trust.
module seg_sync_filter #(
   parameter int STABLE_CYC = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] an,
   input  logic [7:0] seg,
   output logic [7:0] an_s,
   output logic [7:0] seg_s,
   output logic       stable_pulse,
   output logic       settled
);

   localparam int CW = $clog2(STABLE_CYC + 1);

   logic [7:0]    an_m, seg_m;
   logic [15:0]   prev;
   logic [CW-1:0] cnt;
   logic          changed;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         an_m  <= 8'hFF;
         seg_m <= 8'hFF;
         an_s  <= 8'hFF;
         seg_s <= 8'hFF;
      end else begin
         an_m  <= an;
         seg_m <= seg;
         an_s  <= an_m;
         seg_s <= seg_m;
      end
   end

   assign changed = ({an_s, seg_s} != prev);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         prev <= 16'hFFFF;
         cnt  <= '0;
      end else begin
         prev <= {an_s, seg_s};
         if (changed)
            cnt <= '0;
         else if (cnt != CW'(STABLE_CYC))
            cnt <= cnt + 1'b1;
      end
   end

   // Fires in the cycle before the count saturates, so the FSM lands in
   // CAPTURE exactly when the dwell reaches STABLE_CYC.
   assign stable_pulse = !changed && (cnt == CW'(STABLE_CYC - 1));
   assign settled      = (cnt == CW'(STABLE_CYC));

endmodule

// File: rtl/seg_scan_decoder.sv
// Rebuilds the 32-bit hex value shown on a scanned 8-digit 7-segment display
// from its active-low an/seg pins, with frame error and staleness flags.
//
// state          | meaning
// ST_WAIT_STABLE | pins changed recently, waiting for the dwell to settle
// ST_CAPTURE     | one cycle: latch the selected digit if an is one-hot-low
// ST_HOLD        | digit taken for this dwell, wait for the pins to move
module seg_scan_decoder
   import seg_pkg::*;
#(
   parameter int STABLE_CYC  = 16,
   parameter int TIMEOUT_CYC = 1_000_000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  an,
   input  logic [7:0]  seg,
   output logic [31:0] value,
   output logic [7:0]  dp,
   output logic [7:0]  blank,
   output logic        frame_valid,
   output logic        frame_err,
   output logic        stale
);

   localparam int TW = $clog2(TIMEOUT_CYC);

   logic          rst_meta, rst_int;
   logic [7:0]    an_s, seg_s;
   logic          stable_pulse, settled;
   scan_state_t   state, state_nxt;

   logic [31:0]   sh_nib, nib_upd;
   logic [7:0]    sh_dp, dp_upd;
   logic [7:0]    sh_err, err_upd;
   logic [7:0]    sh_blank, blank_upd;
   logic [7:0]    mask, mask_upd;
   logic [7:0]    sel;
   logic [5:0]    dec;
   logic          capture, expire;
   logic [TW-1:0] tcnt;

   // Assert asynchronously, release on the clock.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rst_meta <= 1'b0;
         rst_int  <= 1'b0;
      end else begin
         rst_meta <= 1'b1;
         rst_int  <= rst_meta;
      end
   end

   seg_sync_filter #(.STABLE_CYC(STABLE_CYC)) u_sync_filter (
      .clk          (clk),
      .rst          (rst_int),
      .an           (an),
      .seg          (seg),
      .an_s         (an_s),
      .seg_s        (seg_s),
      .stable_pulse (stable_pulse),
      .settled      (settled)
   );

   always_ff @(posedge clk or negedge rst_int) begin
      if (!rst_int)
         state <= ST_WAIT_STABLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_WAIT_STABLE: if (stable_pulse) state_nxt = ST_CAPTURE;
         ST_CAPTURE:     state_nxt = ST_HOLD;
         ST_HOLD: begin
            if (stable_pulse)
               state_nxt = ST_CAPTURE;
            else if (!settled)
               state_nxt = ST_WAIT_STABLE;
         end
         default:        state_nxt = ST_WAIT_STABLE;
      endcase
   end

   always_comb begin
      sel       = ~an_s;
      dec       = seg_decode(seg_s[6:0]);
      capture   = (state == ST_CAPTURE) && $onehot(sel);
      nib_upd   = sh_nib;
      dp_upd    = sh_dp;
      err_upd   = sh_err;
      blank_upd = sh_blank;
      for (int i = 0; i < 8; i++) begin
         if (sel[i]) begin
            nib_upd[4*i +: 4] = dec[3:0];
            dp_upd[i]         = ~seg_s[7];
            blank_upd[i]      = dec[4];
            err_upd[i]        = dec[5];
         end
      end
      mask_upd  = mask | sel;
      expire    = (tcnt == TW'(TIMEOUT_CYC - 1));
   end

   always_ff @(posedge clk or negedge rst_int) begin
      if (!rst_int) begin
         sh_nib      <= '0;
         sh_dp       <= '0;
         sh_err      <= '0;
         sh_blank    <= '0;
         mask        <= '0;
         tcnt        <= '0;
         value       <= '0;
         dp          <= '0;
         blank       <= '0;
         frame_valid <= 1'b0;
         frame_err   <= 1'b0;
         stale       <= 1'b1;
      end else begin
         frame_valid <= 1'b0;
         if (capture) begin
            tcnt   <= '0;
            sh_nib <= nib_upd;
            sh_dp  <= dp_upd;
            if (mask_upd == 8'hFF) begin
               value       <= nib_upd;
               dp          <= dp_upd;
               blank       <= blank_upd;
               frame_err   <= |err_upd;
               frame_valid <= 1'b1;
               stale       <= 1'b0;
               mask        <= '0;
               sh_err      <= '0;
               sh_blank    <= '0;
            end else begin
               mask     <= mask_upd;
               sh_err   <= err_upd;
               sh_blank <= blank_upd;
            end
         end else if (expire) begin
            // Partial frame abandoned; value keeps the last good frame.
            tcnt     <= '0;
            mask     <= '0;
            sh_nib   <= '0;
            sh_dp    <= '0;
            sh_err   <= '0;
            sh_blank <= '0;
            stale    <= 1'b1;
         end else begin
            tcnt <= tcnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Scoreboard bench for seg_scan_decoder: expected frames are queued as each
// scan is driven and compared whenever frame_valid pulses.
module tb_seg_scan_decoder;

   localparam int STABLE_CYC  = 16;
   localparam int TIMEOUT_CYC = 2000;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [7:0]  an  = 8'hFF;
   logic [7:0]  seg = 8'hFF;
   logic [31:0] value;
   logic [7:0]  dp;
   logic [7:0]  blank;
   logic        frame_valid;
   logic        frame_err;
   logic        stale;

   typedef struct packed {
      logic [31:0] value;
      logic [7:0]  dp;
      logic [7:0]  blank;
      logic        err;
   } frame_t;

   frame_t     exp_q[$];
   frame_t     mon_e;
   int         n_chk = 0;
   int         n_pass = 0;
   int         cyc = 0;
   int         fv_count = 0;
   int         n_pushed = 0;
   int         last_fv_cyc = 0;
   int         drv_cyc = 0;
   logic [6:0] hex_pat [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   seg_scan_decoder #(.STABLE_CYC(STABLE_CYC), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
      .clk         (clk),
      .rst         (rst),
      .an          (an),
      .seg         (seg),
      .value       (value),
      .dp          (dp),
      .blank       (blank),
      .frame_valid (frame_valid),
      .frame_err   (frame_err),
      .stale       (stale)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_chk++;
      if (obs === exp_v)
         n_pass++;
      else
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp_v);
   endtask

   function automatic logic [7:0] dig(input int h, input bit dp_on);
      return {~dp_on, hex_pat[h]};
   endfunction

   task automatic drive_raw(input logic [7:0] an_v, input logic [7:0] seg_v, input int cycles);
      @(negedge clk);
      an      = an_v;
      seg     = seg_v;
      drv_cyc = cyc;
      repeat (cycles - 1) @(negedge clk);
   endtask

   task automatic show(input int idx, input logic [7:0] pat, input int cycles);
      logic [7:0] onehot;
      onehot = 8'h01 << idx;
      drive_raw(~onehot, pat, cycles);
   endtask

   task automatic push_frame(input logic [31:0] v, input logic [7:0] d, input logic [7:0] b, input logic e);
      exp_q.push_back('{value: v, dp: d, blank: b, err: e});
      n_pushed++;
   endtask

   task automatic settle(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_value"}, value, 32'h0);
      check_eq({tag, "_dp"}, 32'(dp), 32'h0);
      check_eq({tag, "_blank"}, 32'(blank), 32'h0);
      check_eq({tag, "_frame_valid"}, 32'(frame_valid), 32'h0);
      check_eq({tag, "_frame_err"}, 32'(frame_err), 32'h0);
      check_eq({tag, "_stale"}, 32'(stale), 32'h1);
   endtask

   always @(negedge clk) begin
      if (frame_valid === 1'b1) begin
         fv_count++;
         last_fv_cyc = cyc;
         check_eq("frame_expected", 32'(exp_q.size() != 0), 32'h1);
         if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            check_eq("frame_value", value, mon_e.value);
            check_eq("frame_dp", 32'(dp), 32'(mon_e.dp));
            check_eq("frame_blank", 32'(blank), 32'(mon_e.blank));
            check_eq("frame_err", 32'(frame_err), 32'(mon_e.err));
            check_eq("frame_stale", 32'(stale), 32'h0);
         end
      end
   end

   initial begin
      repeat (3) @(negedge clk);
      #1;
      check_reset_outputs("reset");
      @(negedge clk);
      rst = 1'b1;
      repeat (4) @(negedge clk);

      // Normal frame 8,7,...,1 with dp on digit 2
      for (int i = 0; i < 7; i++) show(i, dig(8 - i, i == 2), 20);
      push_frame(32'h12345678, 8'h04, 8'h00, 1'b0);
      show(7, dig(1, 0), 20);
      settle(5);
      check_eq("latency", 32'(last_fv_cyc - drv_cyc), 32'd20);
      check_eq("normal_count", 32'(fv_count), 32'(n_pushed));
      check_eq("normal_stale", 32'(stale), 32'h0);
      check_eq("fv_one_cycle", 32'(frame_valid), 32'h0);

      // Blank digit and dp on both ends
      show(0, dig(10, 1), 20);
      show(1, dig(11, 0), 20);
      show(2, dig(12, 0), 20);
      show(3, dig(13, 0), 20);
      show(4, dig(14, 0), 20);
      show(5, 8'hFF, 20);
      show(6, dig(15, 0), 20);
      push_frame(32'h0F0EDCBA, 8'h81, 8'h20, 1'b0);
      show(7, dig(0, 1), 20);
      settle(5);

      // Glitch on digit 7 must not count toward the frame
      show(7, dig(9, 0), 10);
      for (int i = 0; i < 7; i++) show(i, dig(i, 0), 20);
      settle(30);
      check_eq("glitch_no_frame", 32'(fv_count), 32'(n_pushed));
      push_frame(32'h76543210, 8'h00, 8'h00, 1'b0);
      show(7, dig(7, 0), 20);
      settle(5);

      // Illegal pattern on digit 3
      for (int i = 0; i < 3; i++) show(i, dig(i + 1, 0), 20);
      show(3, 8'hD5, 20);
      for (int i = 4; i < 7; i++) show(i, dig(i + 1, 0), 20);
      push_frame(32'h87650321, 8'h00, 8'h00, 1'b1);
      show(7, dig(8, 0), 20);
      settle(30);
      check_eq("err_held", 32'(frame_err), 32'h1);

      // Two digits enabled at once mid-frame
      for (int i = 0; i < 4; i++) show(i, dig(15 - i, 0), 20);
      drive_raw(8'hFC, dig(5, 0), 40);
      for (int i = 4; i < 7; i++) show(i, dig(15 - i, 0), 20);
      push_frame(32'h89ABCDEF, 8'h00, 8'h00, 1'b0);
      show(7, dig(8, 0), 20);
      settle(5);
      check_eq("bad_an_err_clear", 32'(frame_err), 32'h0);

      // Timeout: partial frame discarded, stale raised, value kept
      for (int i = 0; i < 5; i++) show(i, dig(i + 1, 0), 20);
      drive_raw(8'hFF, 8'hFF, 1900);
      #1;
      check_eq("pre_timeout_stale", 32'(stale), 32'h0);
      check_eq("pre_timeout_no_frame", 32'(fv_count), 32'(n_pushed));
      settle(200);
      check_eq("timeout_stale", 32'(stale), 32'h1);
      check_eq("timeout_value_kept", value, 32'h89ABCDEF);
      for (int i = 5; i < 8; i++) show(i, dig(8 - i, 0), 20);
      settle(40);
      check_eq("timeout_mask_cleared", 32'(fv_count), 32'(n_pushed));
      for (int i = 0; i < 4; i++) show(i, dig(i + 4, 0), 20);
      push_frame(32'h12387654, 8'h00, 8'h00, 1'b0);
      show(4, dig(8, 0), 20);
      settle(5);
      check_eq("recover_stale", 32'(stale), 32'h0);

      // Reset mid-frame
      for (int i = 0; i < 4; i++) show(i, dig(0, 0), 20);
      @(negedge clk);
      #3;
      rst = 1'b0;
      #1;
      check_reset_outputs("midreset");
      an  = 8'hFF;
      seg = 8'hFF;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      repeat (4) @(negedge clk);
      for (int i = 4; i < 8; i++) show(i, dig(i, 0), 20);
      settle(40);
      check_eq("reset_partial_dropped", 32'(fv_count), 32'(n_pushed));
      for (int i = 0; i < 3; i++) show(i, dig(i, 0), 20);
      push_frame(32'h76543210, 8'h00, 8'h00, 1'b0);
      show(3, dig(3, 0), 20);
      settle(5);

      check_eq("queue_empty", 32'(exp_q.size()), 32'h0);
      check_eq("frame_count", 32'(fv_count), 32'(n_pushed));
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
